// File: rtl/edge_event_ctrl_pkg.sv
// Shared types and constants for the edge-event controller.
package gcd_pack;

    // Per-channel edge qualification mode.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // Fewest synchroniser flops that still give a reasonable MTBF.
    localparam int EDGE_SYNC_MIN = 2;

endpackage

// File: rtl/edge_event_ctrl_chan.sv
// One channel: synchroniser -> optional debounce filter -> edge detector
// -> sticky pending/overflow latch with write-1-to-clear.
module edge_chan
    import gcd_pack::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       edge_pulse,
    output logic       pending,
    output logic       overflow
);

    // A request for fewer stages than the safe minimum is raised to it.
    localparam int STAGES = (SYNC_STAGES < EDGE_SYNC_MIN) ? EDGE_SYNC_MIN : SYNC_STAGES;
    localparam int CNT_W  = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;

    logic [STAGES-1:0] sync_q, sync_d;
    logic              sync_out;
    logic              filt;
    logic              prev_q, prev_d;
    logic              edge_pulse_q, edge_pulse_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              rise, fall, qual;
    edge_mode_t        mode_e;

    assign sync_out = sync_q[STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_comb sync_d = {sync_q[STAGES-2:0], din};

    // Synchroniser register.
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign filt = sync_out;
        end else begin : g_filter
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

            logic             filt_q, filt_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Accept the synchronised value once it has disagreed for FILTER_LEN cycles.
            always_comb begin
                // NOTE: defaults first, so every path assigns every output and no latch is inferred.
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync_out != filt_q) begin
                    if (cnt_q == CNT_LAST) filt_d = sync_out;
                    else                   cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            // Filter state register; reset discards any count in progress.
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    // Edge detect, mode qualification and pending/overflow next-state.
    always_comb begin
        mode_e = edge_mode_t'(mode);
        rise   = filt & ~prev_q;
        fall   = ~filt & prev_q;
        qual   = 1'b0;
        case (mode_e)
            EDGE_RISE: qual = rise;
            EDGE_FALL: qual = fall;
            EDGE_BOTH: qual = rise | fall;
            default:   qual = 1'b0;
        endcase

        prev_d       = filt;
        edge_pulse_d = qual;

        // A new edge wins over clr so it is never lost.
        if (qual)     pending_d = 1'b1;
        else if (clr) pending_d = 1'b0;
        else          pending_d = pending_q;

        // clr always empties overflow; an edge on a set flag marks a lost event.
        if (clr)                   overflow_d = 1'b0;
        else if (qual & pending_q) overflow_d = 1'b1;
        else                       overflow_d = overflow_q;
    end

    // Detector and event-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= 1'b0;
            edge_pulse_q <= 1'b0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            edge_pulse_q <= edge_pulse_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign edge_pulse = edge_pulse_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/edge_event_ctrl.sv
// Multi-channel edge-event controller: independent channels plus an
// interrupt line that is high while any channel has a pending event.
module edge_event_ctrl #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   edge_pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   overflow,
    output logic                  irq
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (in[ch]),
            .mode       (mode[2*ch+1:2*ch]),
            .clr        (clr[ch]),
            .edge_pulse (edge_pulse[ch]),
            .pending    (pending[ch]),
            .overflow   (overflow[ch])
        );
    end

    // Interrupt is the OR of the registered pending flags.
    always_comb irq = |pending;

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Bench for edge_event_ctrl: an unfiltered and a FILTER_LEN=4 instance share
// stimulus; both are compared every cycle against a history-based model.
module tb_edge_event_ctrl;
    import gcd_pack::*;

    localparam int C  = 8;
    localparam int S  = 2;
    localparam int HL = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [C-1:0]   in_v, clr_v;
    logic [2*C-1:0] mode_v;
    logic [C-1:0]   pulse0, pend0, ovf0, pulse4, pend4, ovf4;
    logic           irq0, irq4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_event_ctrl #(.CHANNELS(C), .SYNC_STAGES(S), .FILTER_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .edge_pulse(pulse0), .pending(pend0), .overflow(ovf0), .irq(irq0));

    edge_event_ctrl #(.CHANNELS(C), .SYNC_STAGES(S), .FILTER_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
        .edge_pulse(pulse4), .pending(pend4), .overflow(ovf4), .irq(irq4));

    // Model: s_hist[d][k] = input sampled k edges ago, f_hist[d][k] = filtered value k edges ago.
    logic [C-1:0] s_hist [2][HL];
    logic [C-1:0] f_hist [2][HL];
    logic [C-1:0] exp_pulse [2];
    logic [C-1:0] exp_pend  [2];
    logic [C-1:0] exp_ovf   [2];

    typedef struct {
        logic           rst;
        logic [C-1:0]   in;
        logic [2*C-1:0] mode;
        logic [C-1:0]   clr;
        logic [3:0]     exp;   // {irq, overflow[0], pending[0], edge_pulse[0]} of dut0
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        int           fl;
        logic [C-1:0] f1, f2, fnew, qual;
        logic         rise, fall, all_opp;
        fl = (d == 0) ? 0 : 4;
        if (rst) begin
            for (int k = 0; k < HL; k++) begin
                s_hist[d][k] = '0;
                f_hist[d][k] = '0;
            end
            exp_pulse[d] = '0;
            exp_pend[d]  = '0;
            exp_ovf[d]   = '0;
            return;
        end
        for (int k = HL - 1; k > 0; k--) s_hist[d][k] = s_hist[d][k-1];
        s_hist[d][0] = in_v;
        f1   = f_hist[d][0];
        f2   = f_hist[d][1];
        fnew = '0;
        qual = '0;
        for (int ch = 0; ch < C; ch++) begin
            // Filtered value flips only when the last fl synchronised samples all oppose it.
            if (fl == 0) fnew[ch] = s_hist[d][S-1][ch];
            else begin
                all_opp = 1'b1;
                for (int k = 0; k < fl; k++)
                    if (s_hist[d][S+k][ch] == f1[ch]) all_opp = 1'b0;
                fnew[ch] = all_opp ? ~f1[ch] : f1[ch];
            end
            rise = f1[ch] & ~f2[ch];
            fall = ~f1[ch] & f2[ch];
            case (edge_mode_t'(mode_v[2*ch +: 2]))
                EDGE_RISE: qual[ch] = rise;
                EDGE_FALL: qual[ch] = fall;
                EDGE_BOTH: qual[ch] = rise | fall;
                default:   qual[ch] = 1'b0;
            endcase
        end
        exp_ovf[d]   = (exp_ovf[d] | (qual & exp_pend[d])) & ~clr_v;
        exp_pend[d]  = qual | (exp_pend[d] & ~clr_v);
        exp_pulse[d] = qual;
        for (int k = HL - 1; k > 0; k--) f_hist[d][k] = f_hist[d][k-1];
        f_hist[d][0] = fnew;
    endtask

    // One clock: advance models at the edge, compare both DUTs 1ns later.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("model_f0", {irq0, ovf0, pend0, pulse0},
              {|exp_pend[0], exp_ovf[0], exp_pend[0], exp_pulse[0]});
        check("model_f4", {irq4, ovf4, pend4, pulse4},
              {|exp_pend[1], exp_ovf[1], exp_pend[1], exp_pulse[1]});
    endtask

    task automatic add_vec(input logic r, input logic i0, input logic [1:0] m,
                           input logic c0, input logic [3:0] e);
        vec_t v;
        v.rst  = r;
        v.in   = {{(C-1){1'b0}}, i0};
        v.mode = {C{m}};
        v.clr  = {{(C-1){1'b0}}, c0};
        v.exp  = e;
        vq.push_back(v);
    endtask

    initial begin
        int pulse_at, pulse_cnt;

        rst    = 1'b1;
        in_v   = '0;
        clr_v  = '0;
        mode_v = {C{EDGE_RISE}};

        // ---- Table: unfiltered channel 0, exp = {irq, ovf, pend, pulse} ----
        add_vec(1, 0, EDGE_RISE, 0, 4'b0000);   // reset
        add_vec(0, 0, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 1, EDGE_RISE, 0, 4'b0000);   // rise sampled at edge k
        add_vec(0, 1, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 1, EDGE_RISE, 0, 4'b1011);   // pulse at k+2
        add_vec(0, 1, EDGE_RISE, 0, 4'b1010);
        add_vec(0, 0, EDGE_RISE, 0, 4'b1010);   // fall ignored in RISE
        add_vec(0, 0, EDGE_RISE, 0, 4'b1010);
        add_vec(0, 0, EDGE_RISE, 0, 4'b1010);
        add_vec(0, 0, EDGE_RISE, 1, 4'b0000);   // clr
        add_vec(0, 1, EDGE_BOTH, 0, 4'b0000);   // mode change alone: no event
        add_vec(0, 1, EDGE_BOTH, 0, 4'b0000);
        add_vec(0, 0, EDGE_BOTH, 0, 4'b1011);
        add_vec(0, 0, EDGE_BOTH, 0, 4'b1010);
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1111);   // fall while pending -> overflow
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1110);
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1111);
        add_vec(0, 1, EDGE_BOTH, 1, 4'b0000);   // clr both flags
        add_vec(0, 0, EDGE_BOTH, 0, 4'b0000);
        add_vec(0, 1, EDGE_BOTH, 0, 4'b0000);
        add_vec(0, 0, EDGE_BOTH, 0, 4'b1011);
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1111);
        add_vec(0, 1, EDGE_BOTH, 1, 4'b1011);   // edge + clr: pending stays, overflow clears
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1111);
        add_vec(0, 1, EDGE_BOTH, 0, 4'b1110);
        add_vec(0, 0, EDGE_OFF,  0, 4'b1110);   // OFF: toggles ignored, flags kept
        add_vec(0, 1, EDGE_OFF,  0, 4'b1110);
        add_vec(0, 0, EDGE_OFF,  0, 4'b1110);
        add_vec(0, 0, EDGE_OFF,  0, 4'b1110);
        add_vec(0, 0, EDGE_OFF,  0, 4'b1110);
        add_vec(0, 0, EDGE_BOTH, 0, 4'b1110);
        add_vec(0, 0, EDGE_BOTH, 1, 4'b0000);
        add_vec(1, 1, EDGE_RISE, 0, 4'b0000);   // reset with input high
        add_vec(0, 1, EDGE_RISE, 0, 4'b0000);   // first edge out of reset
        add_vec(0, 1, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 1, EDGE_RISE, 0, 4'b1011);   // event 2 cycles later
        add_vec(0, 1, EDGE_RISE, 0, 4'b1010);
        add_vec(1, 0, EDGE_RISE, 0, 4'b0000);   // reset with input low
        add_vec(0, 0, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 0, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 0, EDGE_RISE, 0, 4'b0000);
        add_vec(0, 0, EDGE_RISE, 0, 4'b0000);

        for (int j = 0; j < vq.size(); j++) begin
            rst    = vq[j].rst;
            in_v   = vq[j].in;
            mode_v = vq[j].mode;
            clr_v  = vq[j].clr;
            step();
            check($sformatf("vec%0d", j), {irq0, ovf0[0], pend0[0], pulse0[0]}, vq[j].exp);
        end

        // ---- Filter rejection: 3-cycle glitch on the FILTER_LEN=4 instance ----
        rst = 1'b0; clr_v = '1; in_v = '0; mode_v = {C{EDGE_RISE}};
        step();
        clr_v = '0;
        repeat (8) step();
        pulse_cnt = 0;
        in_v = 8'h01;
        repeat (3) begin step(); pulse_cnt += int'(pulse4[0]); end
        in_v = '0;
        repeat (12) begin step(); pulse_cnt += int'(pulse4[0]); end
        check("glitch_rejected", pulse_cnt, 0);

        // ---- 4-cycle pulse accepted exactly at k+6 ----
        pulse_at = -1; pulse_cnt = 0;
        in_v = 8'h01;
        for (int n = 0; n < 12; n++) begin
            if (n == 4) in_v = '0;
            step();
            if (pulse4[0]) begin
                pulse_cnt++;
                if (pulse_at < 0) pulse_at = n;
            end
        end
        check("filter_latency", pulse_at, 6);
        check("filter_pulse_count", pulse_cnt, 1);

        // ---- 8-channel simultaneous step ----
        clr_v = '1; step(); clr_v = '0;
        repeat (8) step();
        in_v = '1;
        repeat (6) step();
        check("step8_before", pend4, 8'h00);
        step();
        check("step8_all_pending", pend4, 8'hFF);
        check("step8_irq", irq4, 1'b1);

        // ---- Reset mid filter count, input held high across release ----
        in_v = '0; clr_v = '1; step(); clr_v = '0;
        repeat (8) step();
        in_v = '1;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_clears_f4", {pulse4, pend4, ovf4, irq4}, 25'd0);
        check("rst_clears_f0", {pulse0, pend0, ovf0, irq0}, 25'd0);
        rst = 1'b0;
        repeat (2) step();
        check("rel_f0_before", pend0, 8'h00);
        step();
        check("rel_f0_event", {pulse0, pend0}, 16'hFFFF);
        repeat (3) step();
        check("rel_f4_before", pend4, 8'h00);
        step();
        check("rel_f4_event", {irq4, pend4}, 9'h1FF);

        // ---- Input low across reset: nothing ----
        in_v = '0; rst = 1'b1; step(); rst = 1'b0;
        repeat (10) step();
        check("low_reset_quiet", {pend0, pend4}, 16'h0000);

        // ---- Randomised run against the model ----
        for (int t = 0; t < 3000; t++) begin
            for (int ch = 0; ch < C; ch++)
                if ($urandom_range(5) == 0) in_v[ch] = ~in_v[ch];
            if ($urandom_range(31) == 0) mode_v = (2*C)'($urandom);
            clr_v = C'($urandom & $urandom & $urandom);
            rst   = ($urandom_range(199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
